// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I-subset control FSM (option macro: CTRL_ILLEGAL_TRAP_EN)
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic [3:0]       status,
  output logic             regRW,
  output logic             ALUsrc,
  output logic [1:0]       immsrc,
  output logic [4:0]       ALUop,
  output logic             mRW,
  output logic             wb,
  output logic             pcsrc,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] ir;
  logic [2:0]  funct3;
  logic        is_r, is_i, is_lw, is_sw, is_beq, is_ill;
  logic        dec_alusrc;
  logic [1:0]  dec_immsrc;
  logic [4:0]  dec_aluop;
  logic        in_instr;
  logic        end_state;
  logic        unused_bits;

  assign funct3 = ir[14:12];

  // Instruction and status bits the controller never inspects.
  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], status[3:1]};

  // Classify the latched instruction by opcode.
  always_comb begin
    is_r   = (ir[6:0] == OP_R);
    is_i   = (ir[6:0] == OP_I);
    is_lw  = (ir[6:0] == OP_LW);
    is_sw  = (ir[6:0] == OP_SW);
    is_beq = (ir[6:0] == OP_BEQ);
    is_ill = !(is_r || is_i || is_lw || is_sw || is_beq);
  end

  // Datapath controls implied by the instruction class; illegal opcodes keep the idle values.
  always_comb begin
    dec_alusrc = 1'b1;
    dec_immsrc = 2'b00;
    dec_aluop  = 5'b00000;
    if (is_r) begin
      dec_aluop  = {1'b0, ir[30], funct3};
    end else if (is_i) begin
      dec_alusrc = 1'b0;
      dec_aluop  = {1'b0, (funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
    end else if (is_lw) begin
      dec_alusrc = 1'b0;
    end else if (is_sw) begin
      dec_alusrc = 1'b0;
      dec_immsrc = 2'b01;
    end else if (is_beq) begin
      dec_immsrc = 2'b10;
      dec_aluop  = 5'b01000;
    end
  end

  assign in_instr = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  // Moore outputs; pcsrc in a BEQ EXEC follows the live zero flag.
  always_comb begin
    regRW  = (state == S_WB);
    mRW    = !((state == S_MEM) && is_sw);
    wb     = (state == S_WB) && is_lw;
    pc_en  = ((state == S_EXEC) && (is_beq || is_ill)) || ((state == S_MEM) && is_sw) || (state == S_WB);
    pcsrc  = ((state == S_EXEC) && is_beq) ? ~status[0] : 1'b1;
    ALUsrc = in_instr ? dec_alusrc : 1'b1;
    immsrc = in_instr ? dec_immsrc : 2'b00;
    ALUop  = in_instr ? dec_aluop  : 5'b00000;
    busy   = (state != S_IDLE) && (state != S_HALT);
    halted = (state == S_HALT);
  end

  // The single pc_en cycle is always the last state of an instruction.
  assign end_state = pc_en;

  // Next-state sequencing; run is only sampled when an instruction finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_DECODE: state_nxt = is_ill ? S_HALT : S_EXEC;
`else
      S_DECODE: state_nxt = S_EXEC;
`endif
      S_EXEC: begin
        if (is_r || is_i)        state_nxt = S_WB;
        else if (is_lw || is_sw) state_nxt = S_MEM;
      end
      S_MEM:    if (is_lw) state_nxt = S_WB;
      S_WB:     state_nxt = S_WB;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
    if (end_state) state_nxt = run ? S_FETCH : S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Instruction register, captured in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ir <= 32'h0;
    else if (state == S_FETCH)  ir <= instr;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired <= '0;
    else if (pc_en) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [3:0]  status = 4'h0;

  logic        regRW, ALUsrc, mRW, wb, pcsrc, pc_en, busy, halted;
  logic [1:0]  immsrc;
  logic [4:0]  ALUop;
  logic [15:0] retired;

  logic        n_regRW, n_ALUsrc, n_mRW, n_wb, n_pcsrc, n_pc_en, n_busy, n_halted;
  logic [1:0]  n_immsrc;
  logic [4:0]  n_ALUop;
  logic [3:0]  n_retired;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status),
    .regRW(regRW), .ALUsrc(ALUsrc), .immsrc(immsrc), .ALUop(ALUop), .mRW(mRW),
    .wb(wb), .pcsrc(pcsrc), .pc_en(pc_en), .busy(busy), .halted(halted), .retired(retired)
  );

  // Narrow counter copy: shows wraparound in a handful of instructions.
  multicycle_ctrl #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status),
    .regRW(n_regRW), .ALUsrc(n_ALUsrc), .immsrc(n_immsrc), .ALUop(n_ALUop), .mRW(n_mRW),
    .wb(n_wb), .pcsrc(n_pcsrc), .pc_en(n_pc_en), .busy(n_busy), .halted(n_halted), .retired(n_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    lat;
    int    pcs;
    int    als;
    int    imm;
    int    op;
    int    wbv;
    int    nrw;
    int    nmw;
    int    ret;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   exp_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Monitor: per-instruction cycle/strobe counters, compared at each pc_en.
  initial begin
    int   cyc = 0, nrw = 0, nmw = 0, npc0 = 0;
    bit   pend = 0;
    int   pend_val = 0;
    string pend_nm;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; nrw = 0; nmw = 0; npc0 = 0; pend = 0;
      end else begin
        if (pend) begin
          chk({pend_nm, "_retired"}, 32'(retired), 32'(pend_val));
          pend = 0;
        end
        if (busy) begin
          cyc++;
          if (regRW) nrw++;
          if (!mRW) nmw++;
          if (!pcsrc && !pc_en) npc0++;
        end
        if (pc_en) begin
          if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_pc_en: got pc_en=1 expected no retirement");
          end else begin
            e = q.pop_front();
            chk({e.nm, "_latency"}, 32'(cyc), 32'(e.lat));
            chk({e.nm, "_pcsrc"}, 32'(pcsrc), 32'(e.pcs));
            chk({e.nm, "_ALUsrc"}, 32'(ALUsrc), 32'(e.als));
            chk({e.nm, "_immsrc"}, 32'(immsrc), 32'(e.imm));
            chk({e.nm, "_ALUop"}, 32'(ALUop), 32'(e.op));
            chk({e.nm, "_wb"}, 32'(wb), 32'(e.wbv));
            chk({e.nm, "_regRW_cycles"}, 32'(nrw), 32'(e.nrw));
            chk({e.nm, "_mRW0_cycles"}, 32'(nmw), 32'(e.nmw));
            chk({e.nm, "_stray_pcsrc0"}, 32'(npc0), 32'd0);
            pend = 1; pend_val = e.ret; pend_nm = e.nm;
          end
          cyc = 0; nrw = 0; nmw = 0; npc0 = 0;
        end else if (!busy) begin
          cyc = 0; nrw = 0; nmw = 0; npc0 = 0;
        end
      end
    end
  end

  // Issue n back-to-back copies of one instruction; run drops during the last one.
  task automatic run_seq(input string nm, input logic [31:0] iw, input logic [3:0] st, input int n,
                         input int lat, input int pcs, input int als, input int imm, input int op,
                         input int wbv, input int nrw, input int nmw);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    instr = iw; status = st; run = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_ret = (exp_ret + 1) % 65536;
      e = '{nm, lat, pcs, als, imm, op, wbv, nrw, nmw, exp_ret};
      q.push_back(e);
      k = 0;
      while (!pc_en && k < 12) begin
        @(posedge clk); #1;
        k++;
      end
      if (!pc_en) begin
        total_cnt++;
        $display("FAIL %s_timeout: got no pc_en within 12 cycles expected pc_en", nm);
        run = 1'b0;
        return;
      end
      if (i == n - 1) run = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_regRW", 32'(regRW), 32'd0);
    chk("rst_mRW", 32'(mRW), 32'd1);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pcsrc", 32'(pcsrc), 32'd1);
    chk("rst_wb", 32'(wb), 32'd0);
    chk("rst_ALUsrc", 32'(ALUsrc), 32'd1);
    chk("rst_immsrc", 32'(immsrc), 32'd0);
    chk("rst_ALUop", 32'(ALUop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge clk); rst = 1'b0;

    //       name      instr         st     n lat pcs als imm op        wb rw mw
    run_seq("add",   32'h002081B3, 4'h0, 1, 4, 1, 1, 0, 5'b00000, 0, 1, 0);
    run_seq("lw",    32'h0000A183, 4'h0, 1, 5, 1, 0, 0, 5'b00000, 1, 1, 0);
    run_seq("sw",    32'h0020A023, 4'h0, 1, 4, 1, 0, 1, 5'b00000, 0, 0, 1);
    run_seq("beq_t", 32'h00208463, 4'h1, 1, 3, 0, 1, 2, 5'b01000, 0, 0, 0);
    run_seq("beq_f", 32'h00208463, 4'h0, 1, 3, 1, 1, 2, 5'b01000, 0, 0, 0);
    run_seq("sub",   32'h40208133, 4'h0, 1, 4, 1, 1, 0, 5'b01000, 0, 1, 0);
    run_seq("srai",  32'h4030D093, 4'h0, 1, 4, 1, 0, 0, 5'b01101, 0, 1, 0);
    run_seq("addi",  32'hFFF00093, 4'h0, 1, 4, 1, 0, 0, 5'b00000, 0, 1, 0);
    run_seq("add2",  32'h002081B3, 4'h0, 2, 4, 1, 1, 0, 5'b00000, 0, 1, 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    @(posedge clk); #1;
    instr = 32'hFFFFFFFF; run = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_retired", 32'(retired), 32'(exp_ret));
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ill_still_halted", 32'(halted), 32'd1);
    chk("ill_retired_hold", 32'(retired), 32'(exp_ret));
    run = 1'b0;
    rst = 1'b1;
    #1;
    chk("ill_rst_halted", 32'(halted), 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_ret = 0;
`else
    run_seq("ill_nop", 32'hFFFFFFFF, 4'h0, 1, 3, 1, 1, 0, 5'b00000, 0, 0, 0);
    chk("nop_halted", 32'(halted), 32'd0);
`endif

    // Reset while SW sits in MEM.
    @(posedge clk); #1;
    instr = 32'h0020A023; run = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("sw_mem_mRW", 32'(mRW), 32'd0);
    run = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort_mRW", 32'(mRW), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_ret = 0;

    run_seq("beq_wrap", 32'h00208463, 4'h0, 18, 3, 1, 1, 2, 5'b01000, 0, 0, 0);
    chk("wrap_retired", 32'(retired), 32'd18);
    chk("wrap_narrow_retired", 32'(n_retired), 32'(18 % 16));

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
